// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the 80-bit packet FIFO word and its reader FSM.
//
// FIFO word layout (show-ahead head word):
//   [63:0]  data
//   [64]    sop
//   [65]    eop
//   [68:66] empty byte count (meaningful with eop)
//   [69]    error
//   [79:70] ignored by the reader
package pkt_fifo_pkg;

  localparam int DATA_LSB  = 0;
  localparam int SOP_BIT   = 64;
  localparam int EOP_BIT   = 65;
  localparam int EMPTY_LSB = 66;
  localparam int ERR_BIT   = 69;
  localparam int WORD_W    = 80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } tx_state_e;

  // Member order mirrors the FIFO word bits [69:0], so a cast of the low
  // 70 bits of a head word yields the beat directly.
  typedef struct packed {
    logic        error;
    logic [2:0]  empty;
    logic        eop;
    logic        sop;
    logic [63:0] data;
  } st_beat_t;

endpackage

// File: rtl/st_out_reg.sv
// Single-register Avalon-ST source stage (ready latency 0).
//
// Ports:
//   clk, arst_n - clock, asynchronous active-low reset
//   load        - a new beat is presented on d this cycle (only honoured
//                 while the slot is free)
//   d           - beat to load
//   tx_ready    - sink ready
//   slot_free   - register can take a new beat this cycle
//   tx_valid    - output beat valid
//   q           - output beat payload (held stable while stalled)
module st_out_reg #(
  parameter int W = 70
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         tx_ready,
  output logic         slot_free,
  output logic         tx_valid,
  output logic [W-1:0] q
);

  // The slot frees up either when empty or when the current beat is being
  // accepted this cycle, allowing back-to-back beats with no bubble.
  assign slot_free = ~tx_valid | tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_valid <= 1'b0;
      q        <= '0;
    end else if (slot_free) begin
      tx_valid <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/fifo_to_st_tx.sv
// Reader for the 8-deep show-ahead packet FIFO feeding the 10G MAC TX
// Avalon-ST port. Pops head words, checks sop/eop framing, enforces an
// inter-packet gap and keeps packet / drop statistics.
//
// Ports:
//   clk, arst_n - clock, asynchronous active-low reset
//   en          - allow new packets to start (a started packet always finishes)
//   fifo_rdata  - FIFO head word (layout in pkt_fifo_pkg)
//   fifo_empty  - FIFO empty flag
//   fifo_rval   - pop strobe, combinational, never asserted while empty
//   tx_*        - registered Avalon-ST source (ready latency 0)
//   pkt_cnt     - eop handshakes, wrapping
//   drop_cnt    - words discarded for missing sop, saturating
//   frame_err   - one-cycle pulse per framing violation
module fifo_to_st_tx
  import pkt_fifo_pkg::*;
#(
  parameter int IPG_CYCLES = 2,
  parameter int IPG_W      = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_rval,
  output logic [63:0]       tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [2:0]        tx_empty,
  output logic              tx_error,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic              frame_err
);

  // The gap counter is loaded with N-1 on the eop pop; together with the
  // cycle spent leaving GAP this puts the next pop N+1 cycles later.
  localparam logic [IPG_W-1:0] GAP_LOAD =
    (IPG_CYCLES == 0) ? '0 : IPG_W'(IPG_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [IPG_W-1:0] gap_q, gap_d;
  st_beat_t         head, beat_d, beat_q;
  logic             slot_free, pop_allowed, load;
  logic             ferr_d, drop_d;
  logic             unused_hi;

  assign head      = st_beat_t'(fifo_rdata[ERR_BIT:DATA_LSB]);
  assign unused_hi = ^fifo_rdata[WORD_W-1:ERR_BIT+1];

  // A packet in flight is always completed, so en only gates IDLE.
  assign pop_allowed = (state_q == IDLE) ? en : (state_q == STREAM);
  assign fifo_rval   = ~fifo_empty & slot_free & pop_allowed;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    load    = 1'b0;
    ferr_d  = 1'b0;
    drop_d  = 1'b0;
    beat_d  = head;
    unique case (state_q)
      IDLE: begin
        if (fifo_rval) begin
          if (head.sop) begin
            load = 1'b1;
            if (head.eop) begin
              state_d = (IPG_CYCLES == 0) ? IDLE : GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = STREAM;
            end
          end else begin
            // Orphan word outside a packet: consume it without forwarding.
            drop_d = 1'b1;
            ferr_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (fifo_rval) begin
          load = 1'b1;
          if (head.sop) begin
            // Nested sop: keep the stream going but mark the beat bad.
            beat_d.error = 1'b1;
            ferr_d       = 1'b1;
          end
          if (head.eop) begin
            state_d = (IPG_CYCLES == 0) ? IDLE : GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - IPG_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  st_out_reg #(
    .W($bits(st_beat_t))
  ) u_out (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (load),
    .d        (beat_d),
    .tx_ready (tx_ready),
    .slot_free(slot_free),
    .tx_valid (tx_valid),
    .q        (beat_q)
  );

  assign tx_data  = beat_q.data;
  assign tx_sop   = beat_q.sop;
  assign tx_eop   = beat_q.eop;
  assign tx_empty = beat_q.empty;
  assign tx_error = beat_q.error;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (tx_valid & tx_ready & tx_eop) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (drop_d && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      frame_err <= ferr_d;
    end
  end

endmodule

// File: tb/tb_fifo_to_st_tx.sv
// Self-checking bench for fifo_to_st_tx: a queue-based FIFO model feeds the
// DUT; a packet-level reference model derives the expected beat stream and
// statistics from the words as they are pushed.
module tb_fifo_to_st_tx;

  localparam int IPG = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic [79:0] fifo_rdata = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rval;
  logic [63:0] tx_data;
  logic        tx_sop, tx_eop, tx_error, tx_valid;
  logic [2:0]  tx_empty;
  logic        tx_ready = 1'b0;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        frame_err;

  always #5 clk = ~clk;

  fifo_to_st_tx #(
    .IPG_CYCLES(IPG),
    .IPG_W     (4)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .en        (en),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_rval (fifo_rval),
    .tx_data   (tx_data),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_empty  (tx_empty),
    .tx_error  (tx_error),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .frame_err (frame_err)
  );

  logic [79:0] fq[$];
  logic [69:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          exp_drop = 0;
  int          exp_ferr = 0;
  int unsigned exp_pkt = 0;
  bit          m_in = 1'b0;
  bit          p_in = 1'b0;
  int          last_end = -1000;
  bit          rval_log[8192];
  bit          valid_log[8192];
  int          ferr_seen = 0;
  int          sop_hs = 0;
  bit          stall_prev = 1'b0;
  logic [69:0] stall_beat = '0;
  int          g_left = 0;

  task automatic check(input string tag, input logic [79:0] obs,
                       input logic [79:0] expected);
    checks++;
    assert (obs === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expected);
    end
  endtask

  function automatic logic [79:0] mk(input logic [63:0] d, input bit sop,
                                     input bit eop, input logic [2:0] empty,
                                     input bit err);
    return {10'h3A5, err, empty, eop, sop, d};
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() == 0) ? '0 : fq[0];
  endtask

  // Reference model: framing rules applied to words in FIFO order.
  task automatic push(input logic [79:0] w);
    logic [69:0] b;
    fq.push_back(w);
    b = w[69:0];
    if (!m_in) begin
      if (!w[64]) begin
        exp_drop++;
        exp_ferr++;
      end else begin
        exp_q.push_back(b);
        if (w[65]) exp_pkt++;
        else m_in = 1'b1;
      end
    end else begin
      if (w[64]) begin
        b[69] = 1'b1;
        exp_ferr++;
      end
      exp_q.push_back(b);
      if (w[65]) begin
        exp_pkt++;
        m_in = 1'b0;
      end
    end
    drive_fifo();
  endtask

  task automatic gen_word(output logic [79:0] w);
    bit first;
    first = (g_left == 0);
    if (first) g_left = $urandom_range(1, 5);
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[79:64] = 16'($urandom);
    w[64]    = first ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0);
    w[65]    = (g_left == 1);
    w[69]    = ($urandom_range(0, 7) == 0);
    g_left--;
  endtask

  // One clock cycle: sample mid-cycle, check, then advance past the edge.
  task automatic tick();
    logic        rv;
    logic [69:0] obs;
    logic [79:0] w;
    #1;
    rv  = fifo_rval;
    obs = {tx_error, tx_empty, tx_eop, tx_sop, tx_data};
    if (cycle < 8192) begin
      rval_log[cycle]  = rv;
      valid_log[cycle] = tx_valid;
    end
    if (frame_err) ferr_seen++;
    if (stall_prev) begin
      check("stall_hold_valid", tx_valid, 1);
      check("stall_hold_beat", obs, stall_beat);
    end
    if (tx_valid && !tx_ready) check("no_pop_while_stalled", rv, 0);
    stall_prev = tx_valid & ~tx_ready;
    stall_beat = obs;
    if (tx_valid && tx_ready) begin
      if (tx_sop) sop_hs++;
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("beat", obs, exp_q.pop_front());
    end
    if (rv) begin
      check("no_underflow", fifo_empty, 0);
      if (fq.size() != 0) begin
        w = fq[0];
        if (!p_in) begin
          check("gap_respected", (cycle - last_end) >= (IPG + 1), 1);
          check("en_honoured", en, 1);
          if (w[64]) begin
            if (w[65]) last_end = cycle;
            else p_in = 1'b1;
          end
        end else if (w[65]) begin
          p_in     = 1'b0;
          last_end = cycle;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rv && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
    cycle++;
  endtask

  function automatic int count_log(input bit sel_valid, input int from,
                                   input int n);
    int c = 0;
    for (int i = from; i < from + n && i < 8192; i++) begin
      if (sel_valid ? valid_log[i] : rval_log[i]) c++;
    end
    return c;
  endfunction

  function automatic int first_rval(input int from, input int to);
    for (int i = from; i < to && i < 8192; i++) begin
      if (rval_log[i]) return i;
    end
    return -1;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    en       = 1'b1;
    tx_ready = 1'b1;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, n < 400, 1);
    repeat (IPG + 3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, c0, c1, s0, f0, n;
    logic [79:0] w;

    // Reset state
    #2;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_beat", {tx_error, tx_empty, tx_eop, tx_sop, tx_data}, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_fifo_rval", fifo_rval, 0);
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (2) tick();

    // 3-word packet, preloaded, en raised in IDLE
    tx_ready = 1'b1;
    push(mk(64'h1111, 1, 0, 3'd0, 0));
    push(mk(64'h2222, 0, 0, 3'd0, 0));
    push(mk(64'h3333, 0, 1, 3'd5, 0));
    repeat (2) tick();
    check("t1_no_pop_while_disabled", count_log(0, cycle - 2, 2), 0);
    mark = cycle;
    en   = 1'b1;
    repeat (8) tick();
    c0 = first_rval(mark, mark + 8);
    check("t1_rval_same_cycle_as_en", c0, mark);
    check("t1_valid_window",
          {valid_log[mark], valid_log[mark+1], valid_log[mark+2],
           valid_log[mark+3], valid_log[mark+4]}, 5'b01110);
    check("t1_pkt_cnt", pkt_cnt, exp_pkt);

    // Two back-to-back single-word packets
    s0   = sop_hs;
    mark = cycle;
    push(mk(64'hA1, 1, 1, 3'd1, 0));
    push(mk(64'hA2, 1, 1, 3'd2, 0));
    repeat (10) tick();
    c0 = first_rval(mark, mark + 10);
    c1 = first_rval(c0 + 1, mark + 10);
    check("t2_ipg_spacing", c1 - c0, IPG + 1);
    check("t2_sop_count", sop_hs - s0, 2);
    check("t2_pkt_cnt", pkt_cnt, exp_pkt);

    // Backpressure mid-packet
    push(mk(64'hB0, 1, 0, 3'd0, 0));
    push(mk(64'hB1, 0, 0, 3'd0, 0));
    push(mk(64'hB2, 0, 0, 3'd0, 0));
    push(mk(64'hB3, 0, 1, 3'd7, 0));
    repeat (2) tick();
    tx_ready = 1'b0;
    mark     = cycle;
    repeat (4) tick();
    check("t3_no_pop_stalled", count_log(0, mark, 4), 0);
    check("t3_held_valid", count_log(1, mark, 4), 4);
    drain("t3");
    check("t3_pkt_cnt", pkt_cnt, exp_pkt);

    // Orphan word in IDLE
    f0   = ferr_seen;
    mark = cycle;
    push(mk(64'hDEAD, 0, 0, 3'd0, 0));
    repeat (6) tick();
    check("t4_popped", fq.size(), 0);
    check("t4_no_valid", count_log(1, mark, 6), 0);
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_frame_err_pulse", ferr_seen - f0, 1);

    // sop inside a packet
    f0 = ferr_seen;
    push(mk(64'hC0, 1, 0, 3'd0, 0));
    push(mk(64'hBEEF, 1, 0, 3'd0, 0));
    push(mk(64'hC2, 0, 1, 3'd4, 0));
    drain("t5");
    check("t5_frame_err_pulse", ferr_seen - f0, 1);
    check("t5_pkt_cnt", pkt_cnt, exp_pkt);

    // en dropped after sop handshake of a 4-word packet
    push(mk(64'hD0, 1, 0, 3'd0, 0));
    push(mk(64'hD1, 0, 0, 3'd0, 0));
    push(mk(64'hD2, 0, 0, 3'd0, 0));
    push(mk(64'hD3, 0, 1, 3'd2, 0));
    push(mk(64'hE0, 1, 0, 3'd0, 0));
    push(mk(64'hE1, 0, 1, 3'd6, 1));
    s0 = sop_hs;
    n  = 0;
    while (sop_hs == s0 && n < 50) begin
      tick();
      n++;
    end
    check("t6_sop_handshake_seen", n < 50, 1);
    en = 1'b0;
    repeat (20) tick();
    check("t6_next_pkt_queued", fq.size(), 2);
    check("t6_first_pkt_done", exp_q.size(), 2);
    check("t6_pkt_cnt_partial", pkt_cnt, exp_pkt - 1);
    drain("t6");
    check("t6_pkt_cnt", pkt_cnt, exp_pkt);

    // Randomized traffic with stray framing, backpressure and en toggling
    for (int i = 0; i < 1500; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 7) != 0);
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) begin
        gen_word(w);
        push(w);
      end
      tick();
    end
    while (g_left != 0 && fq.size() < 8) begin
      gen_word(w);
      push(w);
    end
    drain("rand");

    check("final_pkt_cnt", pkt_cnt, exp_pkt);
    check("final_drop_cnt", drop_cnt, exp_drop);
    check("final_frame_err", ferr_seen, exp_ferr);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_to_st_tx.md
Name: fifo_to_st_tx

Overview:
- Reader end of the 80-bit show-ahead packet FIFO (8 deep, pop-on-rval, head word always on rdata).
- Pops packet words from the FIFO, checks framing, and drives a registered Avalon-ST source toward the 10G MAC TX.
- Enforces a programmable inter-packet gap and keeps packet and drop statistics.

Parameters:
- IPG_CYCLES, 2, idle cycles inserted after an eop word is popped before the next sop may be popped; 0 means no gap.
- IPG_W, 4, width of the gap counter; IPG_CYCLES must be less than 2**IPG_W.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- en  in  1  1 = allow new packets to start; 0 = finish the current packet, then hold
- fifo_rdata  in  80  FIFO head word: [63:0] data, [64] sop, [65] eop, [68:66] empty, [69] error, [79:70] ignored
- fifo_empty  in  1  FIFO empty flag
- fifo_rval  out  1  pop strobe (combinational)
- tx_data  out  64  Avalon-ST data
- tx_sop  out  1  start of packet
- tx_eop  out  1  end of packet
- tx_empty  out  3  empty byte count, valid with eop
- tx_error  out  1  error flag
- tx_valid  out  1  valid
- tx_ready  in  1  sink ready, ready latency 0
- pkt_cnt  out  32  packets sent: eop handshakes, wrapping
- drop_cnt  out  16  words dropped, saturating at 16'hFFFF
- frame_err  out  1  one-cycle pulse on any framing violation

Behaviour:
- Reset: all tx_* = 0, tx_valid = 0, pkt_cnt = 0, drop_cnt = 0, frame_err = 0, state = IDLE, gap counter = 0.
- Output stage is a single register.
  - "slot free" = ~tx_valid | tx_ready.
  - An accepted pop loads tx_* on the next edge: tx_valid is high one cycle after fifo_rval.
  - A slot that is free with no pop clears tx_valid.
- fifo_rval = ~fifo_empty & slot_free & pop_allowed. It is never asserted while fifo_empty = 1, so the FIFO never underflows.
- States:
  - IDLE: pop_allowed = en.
    - Head word with sop: forwarded; go to STREAM, or straight to GAP/IDLE if the word also has eop (single-word packet).
    - Head word without sop: popped but not forwarded (tx_valid unaffected by it); drop_cnt + 1; frame_err pulse.
  - STREAM: pop_allowed = 1, independent of en.
    - Every word is forwarded.
    - A word with sop: forwarded with tx_error forced to 1; frame_err pulse; stays in STREAM.
    - A word with eop: forwarded; go to GAP (counter loaded with IPG_CYCLES-1), or to IDLE when IPG_CYCLES = 0.
  - GAP: pop_allowed = 0; counter decrements each cycle; from 0 go to IDLE.
    - With IPG_CYCLES = N, the earliest next pop is N+1 cycles after the eop pop.
- tx_empty and tx_error are passed from FIFO bits [68:66] and [69], except for the forced error above. tx_empty is not masked on non-eop words.
- pkt_cnt increments on tx_valid & tx_ready & tx_eop and wraps at 2**32.
- Simultaneous events:
  - tx_ready = 1 with a pop: the new word replaces the old one with no bubble, giving full throughput of one word per cycle.
  - tx_ready = 0: tx_* holds stable and no pop occurs.
- en falling mid-packet has no effect until eop. en rising in IDLE takes effect in the same cycle (combinational).
- Reset mid-packet: the output drops immediately (async). The FIFO contents are the FIFO's own concern.

Decomposition:
- Shared package pkt_fifo_pkg:
  - field offsets DATA_LSB = 0, SOP_BIT = 64, EOP_BIT = 65, EMPTY_LSB = 66, ERR_BIT = 69, WORD_W = 80;
  - state encoding IDLE = 0, STREAM = 1, GAP = 2.
- One natural sub-module: st_out_reg, the output register with the slot_free logic, reusable for other ST sources.
- Counters and FSM stay in the top module.

Test Plan:
- 3-word packet (sop, -, eop/empty = 5) with FIFO preloaded and tx_ready = 1:
  - tx_valid high for 3 consecutive cycles, starting 1 cycle after the first fifo_rval;
  - tx_empty = 5 with eop;
  - pkt_cnt = 1.
- Two back-to-back 1-word packets with IPG_CYCLES = 2: second fifo_rval exactly 3 cycles after the first; tx_sop seen twice; pkt_cnt = 2.
- tx_ready held 0 for 4 cycles mid-packet: fifo_rval = 0 and tx_data stable throughout; no word lost or duplicated after release.
- Head word without sop in IDLE (data 64'hDEAD): popped; tx_valid stays 0; drop_cnt = 1; frame_err pulses one cycle.
- sop word arriving in STREAM: forwarded with tx_error = 1; frame_err pulse; the following eop word gives pkt_cnt + 1.
- en = 0 asserted after the sop handshake of a 4-word packet: all 4 words sent; the next queued packet is not popped until en = 1. fifo_empty = 1 throughout idle periods: fifo_rval never asserted.
